prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: FILL_WORD, 8'b00000000, value every program word takes on reset.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 n_reset  input  1  asynchronous, active-low reset.
REQ-004 address  input  4  CPU program counter (fetch address).
REQ-005 instr  output  8  instruction word returned to CPU; [7:4] opcode, [3:0] immediate.
REQ-006 load_start  input  1  request to begin a 16-byte program load.
REQ-007 wr_valid  input  1  loader byte valid.
REQ-008 wr_data  input  8  loader byte.
REQ-009 wr_ready  output  1  block accepts wr_data this cycle.
REQ-010 cpu_n_reset  output  1  active-low reset driven to the CPU.
REQ-011 busy  output  1  high while a load is in progress.
REQ-012 done  output  1  one-cycle pulse when a load completes.

Function
REQ-013 Storage SHALL be 16 x 8-bit words, indexed 0..15.
REQ-014 instr SHALL be mem[address], combinational, in every state.
REQ-015 A write to word N and a read of word N in the same cycle SHALL return the old value until the write edge.
REQ-016 The state machine SHALL have exactly three states: RUN, LOAD and RELEASE.
REQ-017 RUN: wr_ready=0 and busy=0; writes SHALL NOT occur; cpu_n_reset=1, except in the first cycle after reset (see REQ-029).
REQ-018 RUN with load_start=1 at an edge: next state LOAD, write pointer <= 0, cpu_n_reset <= 0.
REQ-019 LOAD: wr_ready=1, busy=1, cpu_n_reset=0.
REQ-020 Handshake: a byte SHALL transfer on an edge where wr_valid=1 and wr_ready=1; mem[ptr] <= wr_data and ptr <= ptr+1.
REQ-021 wr_valid=0 in LOAD: pointer and memory SHALL hold; gaps of any length are allowed.
REQ-022 A transfer with ptr=15 SHALL write word 15 and move the state to RELEASE; the pointer wraps to 0.
REQ-023 RELEASE SHALL last exactly one cycle: wr_ready=0, busy=1, cpu_n_reset=0; the next edge moves the state to RUN.
REQ-024 On the RELEASE->RUN edge: cpu_n_reset <= 1, and done SHALL be 1 for that one RUN cycle only.
REQ-025 load_start SHALL be ignored in LOAD and RELEASE.
REQ-026 wr_valid SHALL be ignored in RUN and RELEASE; no write, no pointer change.
REQ-027 cpu_n_reset, wr_ready, busy and done SHALL be registered or decoded from state only, with no combinational path from inputs.
REQ-028 Minimum load time: 16 LOAD cycles + 1 RELEASE cycle from the load_start edge to cpu_n_reset high.

Reset
REQ-029 n_reset=0 SHALL immediately force the following: state=RUN, ptr=0, all words=FILL_WORD, cpu_n_reset=0, wr_ready=0, busy=0, done=0.
REQ-030 cpu_n_reset SHALL stay 0 until the first rising clk edge after n_reset deasserts, then go to 1.
REQ-031 n_reset asserted mid-load SHALL abort the load; no partially loaded contents survive.

Verification
REQ-032 Reset -> for every address instr=00000000; cpu_n_reset=0, wr_ready=0, busy=0, done=0; first edge after release -> cpu_n_reset=1.
REQ-033 load_start pulse, then 16 back-to-back bytes 10110111,00000001,...,10111000,11111111 -> busy for 17 cycles, done pulse 1 cycle; instr@0=10110111, instr@15=11111111, cpu_n_reset low throughout.
REQ-034 wr_valid toggling every other cycle during a load -> exactly 16 bytes written in order; the load takes 32 LOAD cycles + 1 RELEASE cycle.
REQ-035 load_start pulsed again after 5 bytes -> ignored; the 6th byte lands in word 5.
REQ-036 n_reset pulsed after 7 bytes -> RUN; all words 00000000; ptr=0; a subsequent full load succeeds.
REQ-037 wr_valid=1 with wr_data=11111111 in RUN -> wr_ready=0; memory unchanged; busy=0.

Source files
------------

// File: rtl/prog_loader_if.sv
// Fetch and loader handshake signals shared between a program loader and its driver.
// The master side drives the fetch address and the loader stream.
interface prog_loader_if;
    logic [3:0] address;
    logic [7:0] instr;
    logic       load_start;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       cpu_n_reset;
    logic       busy;
    logic       done;

    modport master (
        output address, load_start, wr_valid, wr_data,
        input  instr, wr_ready, cpu_n_reset, busy, done
    );

    modport slave (
        input  address, load_start, wr_valid, wr_data,
        output instr, wr_ready, cpu_n_reset, busy, done
    );
endinterface

// File: rtl/prog_loader.sv
// 16 x 8-bit program store that the CPU fetches from, reloaded by a byte stream
// while the CPU is held in reset.
module prog_loader #(
    parameter logic [7:0] FILL_WORD = 8'b00000000
) (
    input  logic          clk,
    input  logic          n_reset,
    prog_loader_if.slave  bus
);

    typedef enum logic [1:0] {RUN, LOAD, RELEASE} state_e;

    state_e     state_q, state_d;
    logic [3:0] ptr_q, ptr_d;
    logic [7:0] mem_q [16];
    logic       cpu_n_reset_q;
    logic       done_q;
    logic       wr_en;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= RUN;
            ptr_q         <= '0;
            cpu_n_reset_q <= 1'b0;
            done_q        <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) begin
                mem_q[i[3:0]] <= FILL_WORD;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            // CPU leaves reset exactly when the next state is RUN, which also covers
            // the first edge after n_reset deasserts.
            cpu_n_reset_q <= (state_d == RUN);
            done_q        <= (state_q == RELEASE);
            if (wr_en) begin
                mem_q[ptr_q] <= bus.wr_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wr_en   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (bus.load_start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                end
            end
            LOAD: begin
                if (bus.wr_valid) begin
                    wr_en = 1'b1;
                    ptr_d = ptr_q + 4'd1;
                    if (ptr_q == 4'hF) begin
                        state_d = RELEASE;
                    end
                end
            end
            RELEASE: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        bus.wr_ready    = (state_q == LOAD);
        bus.busy        = (state_q != RUN);
        bus.done        = done_q;
        bus.cpu_n_reset = cpu_n_reset_q;
        bus.instr       = mem_q[bus.address];
    end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader against a transaction-level model of the
// program store and load sequence.
module tb_prog_loader;

    logic clk = 1'b0;
    logic n_reset;

    prog_loader_if bus ();

    prog_loader #(.FILL_WORD(8'h00)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    always #50 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: expected memory contents, bytes received so far in a load, and
    // whether the one-cycle release window or the done pulse is pending.
    logic [7:0] m_mem [16];
    bit         m_loading, m_release, m_cpu, m_done;
    int         m_count;

    int busy_cyc, ready_cyc, done_cyc, cpu_low_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_loading = 0;
        m_release = 0;
        m_cpu     = 0;
        m_done    = 0;
        m_count   = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_wr_ready"},    {31'd0, bus.wr_ready},    {31'd0, m_loading});
        check({tag, "_busy"},        {31'd0, bus.busy},        {31'd0, (m_loading || m_release)});
        check({tag, "_done"},        {31'd0, bus.done},        {31'd0, m_done});
        check({tag, "_cpu_n_reset"}, {31'd0, bus.cpu_n_reset}, {31'd0, m_cpu});
        check({tag, "_instr"},       {24'd0, bus.instr},       {24'd0, m_mem[bus.address]});
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 16; a++) begin
            bus.address = 4'(a);
            #1 check({tag, "_sweep"}, {24'd0, bus.instr}, {24'd0, m_mem[a]});
            #1;
        end
    endtask

    task automatic cycle(input logic ls, input logic v, input logic [7:0] d);
        bus.load_start = ls;
        bus.wr_valid   = v;
        bus.wr_data    = d;
        // Half the time during a load, read the word being written this cycle.
        if (m_loading && $urandom_range(0, 1) == 1) bus.address = 4'(m_count);
        else bus.address = 4'($urandom_range(0, 15));
        #1 check("instr_pre_edge", {24'd0, bus.instr}, {24'd0, m_mem[bus.address]});
        @(posedge clk);
        #1;
        if (m_release) begin
            m_release = 0;
            m_cpu     = 1;
            m_done    = 1;
        end else if (m_loading) begin
            m_done = 0;
            if (v) begin
                m_mem[m_count] = d;
                m_count++;
                if (m_count == 16) begin
                    m_loading = 0;
                    m_release = 1;
                    m_count   = 0;
                end
            end
        end else begin
            m_done = 0;
            if (ls) begin
                m_loading = 1;
                m_count   = 0;
                m_cpu     = 0;
            end else begin
                m_cpu = 1;
            end
        end
        check_outputs("cyc");
        if (bus.busy)         busy_cyc++;
        if (bus.wr_ready)     ready_cyc++;
        if (bus.done)         done_cyc++;
        if (!bus.cpu_n_reset) cpu_low_cyc++;
    endtask

    task automatic clear_counts();
        busy_cyc = 0; ready_cyc = 0; done_cyc = 0; cpu_low_cyc = 0;
    endtask

    task automatic async_reset(input string tag);
        #10 n_reset = 1'b0;
        m_reset();
        #1 check_outputs({tag, "_rst"});
        sweep({tag, "_rst"});
        #5 n_reset = 1'b1;
    endtask

    task automatic run_load(input int gap_pct, input bit noise);
        int guard;
        guard = 0;
        cycle(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
        while ((m_loading || m_release) && guard < 500) begin
            cycle(noise ? 1'($urandom_range(0, 1)) : 1'b0,
                  ($urandom_range(0, 99) >= gap_pct), 8'($urandom));
            guard++;
        end
        cycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
        sweep("rand_load");
    endtask

    initial begin
        logic [7:0] pat [16];
        pat = '{8'hB7, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD,
                8'hEF, 8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hB8, 8'hFF};

        n_reset        = 1'b0;
        bus.load_start = 1'b0;
        bus.wr_valid   = 1'b0;
        bus.wr_data    = 8'h00;
        bus.address    = 4'h0;
        m_reset();

        // Reset state and first edge releasing the CPU
        #20 check_outputs("reset");
        sweep("reset");
        #5 n_reset = 1'b1;
        cycle(1'b0, 1'b0, 8'h00);
        check("cpu_release_first_edge", {31'd0, bus.cpu_n_reset}, 32'd1);

        // Back-to-back load
        clear_counts();
        cycle(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, pat[i]);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        check("b2b_busy_cycles",  busy_cyc,    32'd17);
        check("b2b_done_cycles",  done_cyc,    32'd1);
        check("b2b_cpu_low",      cpu_low_cyc, 32'd17);
        check("b2b_ready_cycles", ready_cyc,   32'd16);
        bus.address = 4'h0;
        #1 check("b2b_instr0", {24'd0, bus.instr}, 32'hB7);
        bus.address = 4'hF;
        #1 check("b2b_instr15", {24'd0, bus.instr}, 32'hFF);
        sweep("b2b");

        // wr_valid toggling every other cycle
        clear_counts();
        cycle(1'b1, 1'b0, 8'h00);
        for (int j = 0; j < 32; j++) cycle(1'b0, 1'(j % 2), 8'($urandom));
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        check("toggle_ready_cycles", ready_cyc, 32'd32);
        check("toggle_busy_cycles",  busy_cyc,  32'd33);
        check("toggle_done_cycles",  done_cyc,  32'd1);
        sweep("toggle");

        // load_start again after 5 bytes is ignored
        cycle(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'(8'h40 + i));
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h5A);
        bus.address = 4'h5;
        #1 check("restart_ignored_word5", {24'd0, bus.instr}, 32'h5A);
        for (int i = 6; i < 16; i++) cycle(1'b0, 1'b1, 8'($urandom));
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        sweep("restart");

        // Reset mid-load aborts, then a full load succeeds
        cycle(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 8'($urandom_range(1, 255)));
        async_reset("abort");
        cycle(1'b0, 1'b0, 8'h00);
        run_load(0, 1'b0);

        // Writes in RUN are ignored
        clear_counts();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'hFF);
        check("run_write_busy", busy_cyc,  32'd0);
        check("run_write_ready", ready_cyc, 32'd0);
        sweep("run_write");

        // Random loads with gaps and load_start noise
        for (int k = 0; k < 6; k++) begin
            run_load($urandom_range(0, 70), 1'b1);
            for (int i = 0; i < 3; i++) cycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
